regbus_arbiter: RTL and testbench

- Shares one regmap register port between NUM_REQ requesters, e.g. the AXI-lite bridge and an on-chip reconnect/timing-advance sequencer.
- Sits between the requesters and a frame-sync-style regmap. Uses that regmap's pulse req / delayed ack protocol, with separate write and read channels.
- Round-robin arbitration, one transaction in flight, timeout with error response, overrun detection.

---
 rtl/regbus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_regbus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter sharing one pulse-req / delayed-ack register port between
// NUM_REQ requesters, with per-requester depth-1 slots, timeout and overrun flags.

module regbus_slot #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  input  logic                  free,
  output logic                  pend,
  output logic                  slot_we,
  output logic [ADDR_WIDTH-1:0] slot_addr,
  output logic [31:0]           slot_wdata,
  output logic                  overrun
);
  // The slot stays pending through its whole transaction; the completion
  // cycle frees it, so a request landing on that cycle refills it directly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend       <= 1'b0;
      slot_we    <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= '0;
      overrun    <= 1'b0;
    end else begin
      if (req && (!pend || free)) begin
        pend       <= 1'b1;
        slot_we    <= we;
        slot_addr  <= addr;
        slot_wdata <= wdata;
      end else if (free) begin
        pend <= 1'b0;
      end
      if (req && pend && !free) overrun <= 1'b1;
    end
  end
endmodule

module regbus_arbiter #(
  parameter int          NUM_REQ    = 2,
  parameter int          ADDR_WIDTH = 9,
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ*32-1:0]         wdata_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [31:0]                   rdata_o,
  output logic [NUM_REQ-1:0]            err_o,
  output logic [NUM_REQ-1:0]            overrun_o,
  output logic                          wreq_o,
  output logic [ADDR_WIDTH-1:0]         waddr_o,
  output logic [31:0]                   wdata_o,
  input  logic                          wack_i,
  output logic                          rreq_o,
  output logic [ADDR_WIDTH-1:0]         raddr_o,
  input  logic [31:0]                   rdata_i,
  input  logic                          rack_i,
  output logic                          busy_o,
  output logic [15:0]                   timeout_cnt_o
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [NUM_REQ-1:0]                 pend, slot_we, gnt_oh;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] slot_addr;
  logic [NUM_REQ-1:0][31:0]           slot_wdata;
  logic [GW-1:0]                      grant, ptr, sel, idx;
  logic                               we_q, err_q, done, expire;
  logic [CW-1:0]                      cnt;
  logic [31:0]                        cap, wdata_q;
  logic [ADDR_WIDTH-1:0]              waddr_q, raddr_q;
  logic [15:0]                        tcnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    regbus_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_slot (
      .clk       (clk_i),
      .reset_n   (reset_ni),
      .req       (req_i[i]),
      .we        (we_i[i]),
      .addr      (addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .wdata     (wdata_i[i*32 +: 32]),
      .free      (ack_o[i]),
      .pend      (pend[i]),
      .slot_we   (slot_we[i]),
      .slot_addr (slot_addr[i]),
      .slot_wdata(slot_wdata[i]),
      .overrun   (overrun_o[i])
    );
  end

  // Scan from farthest to nearest so the first pending index after ptr wins.
  always_comb begin
    sel = ptr;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(ptr) + k) % NUM_REQ);
      if (pend[idx]) sel = idx;
    end
  end

  always_comb begin
    gnt_oh        = '0;
    gnt_oh[grant] = 1'b1;
  end

  assign done   = we_q ? wack_i : rack_i;
  assign expire = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pend) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done || expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state   <= IDLE;
      ptr     <= GW'(NUM_REQ - 1);
      grant   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
      cap     <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      tcnt    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (|pend) begin
          grant <= sel;
          ptr   <= sel;
          we_q  <= slot_we[sel];
          if (slot_we[sel]) begin
            waddr_q <= slot_addr[sel];
            wdata_q <= slot_wdata[sel];
          end else begin
            raddr_q <= slot_addr[sel];
          end
        end
        ISSUE: cnt <= '0;
        // A real ack on the expiry cycle takes priority over the timeout.
        WAIT: if (done) begin
          err_q <= 1'b0;
          cap   <= we_q ? 32'h0 : rdata_i;
        end else if (expire) begin
          err_q <= 1'b1;
          cap   <= we_q ? 32'h0 : ERR_DATA;
          if (tcnt != 16'hFFFF) tcnt <= tcnt + 16'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wreq_o        = (state == ISSUE) && we_q;
  assign rreq_o        = (state == ISSUE) && !we_q;
  assign waddr_o       = waddr_q;
  assign raddr_o       = raddr_q;
  assign wdata_o       = wdata_q;
  assign ack_o         = (state == RESP) ? gnt_oh : '0;
  assign err_o         = (state == RESP && err_q) ? gnt_oh : '0;
  assign rdata_o       = (state == RESP) ? cap : 32'h0;
  assign busy_o        = (state != IDLE);
  assign timeout_cnt_o = tcnt;
endmodule

// File: tb/tb_regbus_arbiter.sv
// Scoreboard bench for regbus_arbiter: requests push expected responses, a
// negedge monitor pops and compares them whenever an ack_o bit appears.

module tb_regbus_arbiter;
  localparam int          NR = 2;
  localparam int          AW = 9;
  localparam int          TO = 16;
  localparam logic [31:0] ED = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              reset_ni = 1'b0;
  logic [NR-1:0]     req_i = '0, we_i = '0;
  logic [NR*AW-1:0]  addr_i = '0;
  logic [NR*32-1:0]  wdata_i = '0;
  logic [NR-1:0]     ack_o, err_o, overrun_o;
  logic [31:0]       rdata_o, wdata_o;
  logic              wreq_o, rreq_o, busy_o;
  logic [AW-1:0]     waddr_o, raddr_o;
  logic              wack_i = 1'b0, rack_i = 1'b0;
  logic [31:0]       rdata_i = '0;
  logic [15:0]       timeout_cnt_o;

  regbus_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .TIMEOUT(TO), .ERR_DATA(ED)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o),
    .overrun_o(overrun_o), .wreq_o(wreq_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .wack_i(wack_i), .rreq_o(rreq_o), .raddr_o(raddr_o), .rdata_i(rdata_i),
    .rack_i(rack_i), .busy_o(busy_o), .timeout_cnt_o(timeout_cnt_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          req;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        expq[$];
  int          ack_log[$];
  int          errors = 0, checks = 0;
  int          tcnt_model = 0;
  logic [NR-1:0] exp_ovr = '0;
  int          t_issue = 0, n_issue = 0;
  int          t_ack[NR];
  logic        iss_we;
  logic [8:0]  iss_addr;
  logic [31:0] iss_wdata;
  logic        extra_rack = 1'b0, extra_wack = 1'b0;

  // Slave model: registers in 0x1F0..0x1FF never answer.
  function automatic logic dead(logic [8:0] a);
    return a[8:4] == 5'h1F;
  endfunction

  function automatic logic [31:0] slave_rd(logic [8:0] a);
    if (a == 9'h003) return 32'h46537E7E;
    return 32'h9E3779B9 ^ {a, ~a[8:1], a[5:0], a};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic       s_rd = 1'b0, s_wr = 1'b0;
  logic [8:0] s_addr = '0;
  always @(negedge clk) begin
    s_rd   = rreq_o && !dead(raddr_o);
    s_wr   = wreq_o && !dead(waddr_o);
    s_addr = raddr_o;
  end
  always @(posedge clk) begin
    #2;
    rack_i  = s_rd | extra_rack;
    wack_i  = s_wr | extra_wack;
    rdata_i = s_rd ? slave_rd(s_addr) : 32'h1234_5678;
  end

  // Monitor
  always @(negedge clk) begin
    int k, idx;
    exp_t e;
    if (reset_ni) begin
      if (wreq_o || rreq_o) begin
        chk("single_strobe", 32'(wreq_o && rreq_o), 0);
        iss_we    = wreq_o;
        iss_addr  = wreq_o ? waddr_o : raddr_o;
        iss_wdata = wdata_o;
        t_issue   = cyc;
        n_issue++;
      end
      if (ack_o != '0) begin
        chk("ack_onehot", 32'($countones(ack_o)), 1);
        idx = ack_o[1] ? 1 : 0;
        t_ack[idx] = cyc;
        ack_log.push_back(idx);
        k = -1;
        for (int j = 0; j < expq.size(); j++)
          if (k < 0 && expq[j].req == idx) k = j;
        if (k < 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack_o=%b expected none (cycle %0d)", ack_o, cyc);
        end else begin
          e = expq[k];
          expq.delete(k);
          if (e.err && tcnt_model < 16'hFFFF) tcnt_model++;
          chk("xfer_type", 32'(iss_we), 32'(e.we));
          chk("xfer_addr", 32'(iss_addr), 32'(e.addr));
          if (e.we) chk("xfer_wdata", iss_wdata, e.wdata);
          chk("rdata", rdata_o, e.rdata);
          chk("err", 32'(err_o), e.err ? 32'(ack_o) : 32'h0);
          chk("timeout_cnt", 32'(timeout_cnt_o), 32'(tcnt_model));
          chk("overrun", 32'(overrun_o), 32'(exp_ovr));
        end
      end else begin
        chk("quiet_rdata", rdata_o, 0);
        chk("quiet_err", 32'(err_o), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_i = '0;
  endtask

  task automatic drive(int i, logic we, logic [8:0] a, logic [31:0] d, bit drop);
    exp_t e;
    req_i[i]           = 1'b1;
    we_i[i]            = we;
    addr_i[i*AW +: AW] = a;
    wdata_i[i*32 +: 32] = d;
    if (drop) begin
      exp_ovr[i] = 1'b1;
    end else begin
      e.req   = i;
      e.we    = we;
      e.addr  = a;
      e.wdata = d;
      e.err   = dead(a);
      e.rdata = we ? 32'h0 : (dead(a) ? ED : slave_rd(a));
      expq.push_back(e);
    end
  endtask

  task automatic wait_done(int maxc);
    int n = 0;
    while ((expq.size() != 0 || busy_o) && n < maxc) begin
      tick();
      n++;
    end
    if (n >= maxc) begin
      checks++;
      errors++;
      $display("FAIL wait_done: got %0d outstanding after %0d cycles expected 0", expq.size(), maxc);
      expq.delete();
    end
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    expq.delete();
    tcnt_model = 0;
    exp_ovr    = '0;
    tick();
    tick();
    reset_ni = 1'b1;
  endtask

  function automatic bit has_pending(int i);
    foreach (expq[j]) if (expq[j].req == i) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int t0, n0;
    tick();
    do_reset();
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_ovr", 32'(overrun_o), 0);
    chk("rst_strobes", 32'({wreq_o, rreq_o, busy_o}), 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_addr", 32'({waddr_o, raddr_o}), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_tcnt", 32'(timeout_cnt_o), 0);

    // Single read, then single write
    t0 = cyc;
    drive(0, 1'b0, 9'h003, 32'h0, 0);
    tick();
    wait_done(40);
    chk("rd_issue_lat", 32'(t_issue - t0), 2);
    chk("rd_ack_lat", 32'(t_ack[0] - t0), 4);
    n0 = n_issue;
    drive(1, 1'b1, 9'h011, 32'h1, 0);
    tick();
    wait_done(40);
    chk("wr_one_access", 32'(n_issue - n0), 1);

    // Simultaneous requests, two rounds
    do_reset();
    ack_log.delete();
    t0 = cyc;
    drive(0, 1'b0, 9'h020, 32'h0, 0);
    drive(1, 1'b1, 9'h021, 32'hA5A5_0001, 0);
    tick();
    wait_done(40);
    chk("sim_lat0", 32'(t_ack[0] - t0), 4);
    chk("sim_lat1", 32'(t_ack[1] - t0), 8);
    drive(0, 1'b1, 9'h022, 32'h5A5A_0002, 0);
    drive(1, 1'b0, 9'h023, 32'h0, 0);
    tick();
    wait_done(40);
    chk("rr_count", 32'(ack_log.size()), 4);
    if (ack_log.size() == 4)
      chk("rr_order", 32'({ack_log[0][3:0], ack_log[1][3:0], ack_log[2][3:0], ack_log[3][3:0]}), 32'h0101);

    // Timeout, then a normal transaction
    t0 = cyc;
    drive(0, 1'b0, 9'h0FF | 9'h1F0, 32'h0, 0);
    tick();
    wait_done(60);
    chk("to_lat", 32'(t_ack[0] - t0), 3 + TO);
    chk("to_cnt", 32'(timeout_cnt_o), 1);
    t0 = cyc;
    drive(1, 1'b0, 9'h042, 32'h0, 0);
    tick();
    wait_done(40);
    chk("post_to_lat", 32'(t_ack[1] - t0), 4);

    // Overrun: second pulse one cycle later is dropped
    n0 = n_issue;
    drive(0, 1'b0, 9'h050, 32'h0, 0);
    tick();
    drive(0, 1'b1, 9'h051, 32'hBAD0_BAD0, 1);
    tick();
    wait_done(40);
    chk("ovr_one_access", 32'(n_issue - n0), 1);
    chk("ovr_sticky", 32'(overrun_o), 2'b01);

    // Request coinciding with ack_o is accepted
    drive(1, 1'b0, 9'h060, 32'h0, 0);
    tick();
    tick();
    tick();
    tick();
    chk("ack_cycle", 32'(ack_o), 2'b10);
    drive(1, 1'b1, 9'h061, 32'h0000_0061, 0);
    tick();
    wait_done(40);
    chk("ack_cycle_no_ovr", 32'(overrun_o), 2'b01);

    // Reset mid-WAIT, late slave acks ignored
    drive(0, 1'b0, 9'h1F3, 32'h0, 0);
    tick();
    tick();
    tick();
    reset_ni = 1'b0;
    expq.delete();
    tcnt_model = 0;
    exp_ovr    = '0;
    tick();
    reset_ni   = 1'b1;
    extra_rack = 1'b1;
    extra_wack = 1'b1;
    tick();
    tick();
    extra_rack = 1'b0;
    extra_wack = 1'b0;
    tick();
    chk("rmid_busy", 32'(busy_o), 0);
    chk("rmid_ack", 32'(ack_o), 0);
    chk("rmid_ovr", 32'(overrun_o), 0);
    chk("rmid_tcnt", 32'(timeout_cnt_o), 0);
    t0 = cyc;
    drive(1, 1'b0, 9'h003, 32'h0, 0);
    tick();
    wait_done(40);
    chk("rmid_lat", 32'(t_ack[1] - t0), 4);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NR; i++)
        if (!has_pending(i) && $urandom_range(0, 2) == 0)
          drive(i, 1'(($urandom >> 3) & 1), 9'($urandom), $urandom, 0);
      tick();
    end
    wait_done(200);
    chk("final_ovr", 32'(overrun_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
